bpu_update_queue: RTL and testbench
===================================

# bpu_update_queue

Buffers resolved branch outcomes from the commit stage and drains them, one per cycle and in commit order, into the base predictor's update port (`update_valid` / `update_instr_info`). It sits directly upstream of the bimodal PHT. It decouples up to two committed branches per cycle from the predictor's single update port, so no resolution is lost when two branches commit together.

## Interface
Parameters:
- `DEPTH_EXP2`, default 3: queue depth is 2**DEPTH_EXP2 entries (minimum 1, i.e. 2 entries).
- `PC_WIDTH`, default 32: width of the branch PC.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enq0_valid`  in  1  commit slot 0 carries a resolved branch.
- `enq0_info`  in  PC_WIDTH+1  slot 0 entry, packed as {pc, taken}.
- `enq1_valid`  in  1  commit slot 1 carries a resolved branch (younger than slot 0).
- `enq1_info`  in  PC_WIDTH+1  slot 1 entry, packed as {pc, taken}.
- `enq_ready`  out  1  queue can accept two entries this cycle.
- `update_ready`  in  1  consumer accepts the head this cycle; tie high for the base predictor.
- `update_valid`  out  1  head entry is present.
- `update_instr_info`  out  PC_WIDTH+1  head entry {pc, taken}.
- `count`  out  DEPTH_EXP2+1  current occupancy.
- `overflow`  out  1  sticky: an enqueue was attempted while `enq_ready` was 0.

## Operation
- Storage: circular buffer of 2**DEPTH_EXP2 entries of PC_WIDTH+1 bits.
  - Registers: head pointer, tail pointer (DEPTH_EXP2 bits each, natural wrap modulo depth), occupancy `count` (DEPTH_EXP2+1 bits).
  - Entry storage is not reset.
- Enqueue, only when `enq_ready`=1:
  - Both valid: slot 0 is written at tail, slot 1 at tail+1; tail += 2.
  - One valid (either slot): that entry is written at tail; tail += 1. Slot 1 alone is legal.
  - Neither valid: no change.
- `enq_ready` = (2**DEPTH_EXP2 − `count`) ≥ 2. It is a function of registered `count` only, with no combinational path from `enq*_valid` or `update_ready`.
- Enqueue while `enq_ready`=0:
  - Both slots are discarded; no partial write.
  - `overflow` is set and holds until reset.
  - Committing producers are required never to do this; `overflow` exists for verification.
- Dequeue: when `update_valid`=1 and `update_ready`=1, head += 1.
- Output (show-ahead FIFO):
  - `update_valid` = (`count` ≠ 0).
  - `update_instr_info` = entry at head when `count` ≠ 0, else all zeros.
- Occupancy: `count` next = `count` + number enqueued − number dequeued.
  - Enqueue and dequeue in the same cycle are both performed.
  - `count` never exceeds 2**DEPTH_EXP2 and never underflows.
- Ordering: drain order equals commit order; slot 0 precedes slot 1 within a cycle.

## Timing
- Reset (asynchronous, takes effect immediately):
  - head = tail = `count` = 0, `overflow` = 0.
  - Outputs: `update_valid` = 0, `update_instr_info` = 0, `enq_ready` = 1.
  - Reset asserted mid-operation discards all entries. No update is emitted in the cycle after deassertion.
- Latency: an entry enqueued at edge N appears on `update_*` after edge N (cycle N+1) at the earliest, if the queue was empty.
- Throughput: enqueue up to 2 per cycle; drain 1 per cycle.
- Full-side boundary, depth 8:
  - `count` = 6: `enq_ready` = 1.
  - `count` = 7 or 8: `enq_ready` = 0, even if a dequeue happens the same cycle.
- Empty boundary: with `count` = 0, `update_ready` has no effect, and an enqueue in that cycle is not bypassed to the output in the same cycle.
- Pointer wrap: index 2**DEPTH_EXP2−1 is followed by index 0. A dual write straddling the wrap writes the last index and index 0.

## Test plan
- Reset/idle: assert `rst` asynchronously mid-cycle → `update_valid`=0, `update_instr_info`=0, `enq_ready`=1, `count`=0 immediately. After release with no stimulus, the outputs stay the same.
- Single enqueue: `enq0` = {0x1C000010, 1} at edge N, `update_ready`=1 → cycle N+1 shows `update_valid`=1, `update_instr_info`={0x1C000010, 1}; cycle N+2 shows `update_valid`=0, `count`=0.
- Dual enqueue ordering: both slots valid, {0x100, 0} and {0x104, 1}, with `update_ready`=1 → the next two cycles present 0x100/0 then 0x104/1, then `update_valid`=0.
- Fill/backpressure (DEPTH_EXP2=3, `update_ready`=0): 3 dual enqueues → `count`=6, `enq_ready`=1. One more single enqueue → `count`=7, `enq_ready`=0. A further enqueue attempt → `overflow`=1, `count` stays 7, contents unchanged.
- Wrap and simultaneous: keep `count`≈4 with one dual enqueue and one dequeue per cycle for 20 cycles, with `update_ready` pulsed → pointers wrap, FIFO order is preserved against a scoreboard, and `count` matches the model every cycle.
- Slot-1-only enqueue: `enq1_valid`=1, `enq0_valid`=0, `enq1_info`={0x200, 1} → exactly one entry is queued and appears next cycle; `count`=1.

Source files
------------

// File: rtl/bpu_update_queue.sv
// rtl/bpu_update_queue.sv - dual-enqueue, single-drain queue of resolved branches
// feeding the base predictor's update port in commit order.
module bpu_update_queue #(
  parameter int DEPTH_EXP2 = 3,
  parameter int PC_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enq0_valid,
  input  logic [PC_WIDTH:0]     enq0_info,
  input  logic                  enq1_valid,
  input  logic [PC_WIDTH:0]     enq1_info,
  output logic                  enq_ready,
  input  logic                  update_ready,
  output logic                  update_valid,
  output logic [PC_WIDTH:0]     update_instr_info,
  output logic [DEPTH_EXP2:0]   count,
  output logic                  overflow
);

  localparam int DEPTH = 2 ** DEPTH_EXP2;
  localparam logic [DEPTH_EXP2:0] READY_MAX = (DEPTH_EXP2 + 1)'(DEPTH - 2);

  logic [PC_WIDTH:0]     mem [DEPTH];
  logic [DEPTH_EXP2-1:0] head_q, head_d;
  logic [DEPTH_EXP2-1:0] tail_q, tail_d;
  logic [DEPTH_EXP2-1:0] wr1_idx;
  logic [DEPTH_EXP2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  enq_any, enq_fire, deq_fire;
  logic [1:0]            n_enq;

  // Ready depends only on registered occupancy so producers see no path from their own valids.
  assign enq_ready = (count_q <= READY_MAX);

  always_comb begin
    enq_any    = enq0_valid | enq1_valid;
    enq_fire   = enq_any & enq_ready;
    deq_fire   = (count_q != '0) & update_ready;
    n_enq      = enq_fire ? ({1'b0, enq0_valid} + {1'b0, enq1_valid}) : 2'd0;
    wr1_idx    = enq0_valid ? tail_q + DEPTH_EXP2'(1) : tail_q;
    tail_d     = tail_q + DEPTH_EXP2'(n_enq);
    head_d     = deq_fire ? head_q + DEPTH_EXP2'(1) : head_q;
    count_d    = count_q + (DEPTH_EXP2 + 1)'(n_enq) - (DEPTH_EXP2 + 1)'(deq_fire);
    overflow_d = overflow_q | (enq_any & ~enq_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      if (enq0_valid) mem[tail_q] <= enq0_info;
      if (enq1_valid) mem[wr1_idx] <= enq1_info;
    end
  end

  assign update_valid      = (count_q != '0);
  assign update_instr_info = update_valid ? mem[head_q] : '0;
  assign count             = count_q;
  assign overflow          = overflow_q;

endmodule

// File: tb/tb_bpu_update_queue.sv
// tb/tb_bpu_update_queue.sv - randomized self-checking bench for bpu_update_queue
// against a queue-based reference model.
module tb_bpu_update_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enq0_valid = 1'b0;
  logic [32:0] enq0_info = '0;
  logic        enq1_valid = 1'b0;
  logic [32:0] enq1_info = '0;
  logic        enq_ready;
  logic        update_ready = 1'b0;
  logic        update_valid;
  logic [32:0] update_instr_info;
  logic [3:0]  count;
  logic        overflow;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [32:0] mq[$];
  bit          m_ovf = 1'b0;

  bpu_update_queue #(.DEPTH_EXP2(3), .PC_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .enq0_valid(enq0_valid), .enq0_info(enq0_info),
    .enq1_valid(enq1_valid), .enq1_info(enq1_info),
    .enq_ready(enq_ready), .update_ready(update_ready),
    .update_valid(update_valid), .update_instr_info(update_instr_info),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] exp_info();
    return (mq.size() != 0) ? mq[0] : 33'd0;
  endfunction

  function automatic logic [32:0] rnd_entry();
    return {$urandom(), 1'($urandom_range(0, 1))};
  endfunction

  task automatic model_step();
    int  free;
    bit  any;
    free = DEPTH - mq.size();
    any  = enq0_valid | enq1_valid;
    if (mq.size() != 0 && update_ready) void'(mq.pop_front());
    if (any) begin
      if (free >= 2) begin
        if (enq0_valid) mq.push_back(enq0_info);
        if (enq1_valid) mq.push_back(enq1_info);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    enq0_valid = 1'b0;
    enq1_valid = 1'b0;
    update_ready = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    enq0_valid = 1'b1; enq0_info = rnd_entry();
    enq1_valid = 1'b1; enq1_info = rnd_entry();
    cycle();
    idle_inputs();
    n_checks++;
    if (count !== 4'd2) begin n_fail++; $display("FAIL preload_count got %0d want 2", count); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    mq.delete();
    m_ovf = 1'b0;
    n_checks++;
    if (count !== 4'd0 || update_valid !== 1'b0 || update_instr_info !== 33'd0 || enq_ready !== 1'b1 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got cnt=%0d v=%b info=%h rdy=%b ovf=%b want 0 0 0 1 0",
               count, update_valid, update_instr_info, enq_ready, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if (count !== 4'd0 || update_valid !== 1'b0 || update_instr_info !== 33'd0 || enq_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL idle_after_reset got cnt=%0d v=%b info=%h rdy=%b want 0 0 0 1",
                 count, update_valid, update_instr_info, enq_ready);
      end
    end
  endtask

  task automatic test_single();
    update_ready = 1'b1;
    enq0_valid = 1'b1; enq0_info = {32'h1C000010, 1'b1};
    cycle();
    enq0_valid = 1'b0;
    n_checks++;
    if (update_valid !== 1'b1 || update_instr_info !== {32'h1C000010, 1'b1}) begin
      n_fail++;
      $display("FAIL single_head got v=%b info=%h want 1 %h", update_valid, update_instr_info, {32'h1C000010, 1'b1});
    end
    cycle();
    n_checks++;
    if (update_valid !== 1'b0 || count !== 4'd0) begin
      n_fail++;
      $display("FAIL single_drained got v=%b cnt=%0d want 0 0", update_valid, count);
    end
    idle_inputs();
  endtask

  task automatic test_dual();
    logic [32:0] want [3];
    want[0] = {32'h100, 1'b0};
    want[1] = {32'h104, 1'b1};
    want[2] = 33'd0;
    update_ready = 1'b1;
    enq0_valid = 1'b1; enq0_info = want[0];
    enq1_valid = 1'b1; enq1_info = want[1];
    cycle();
    enq0_valid = 1'b0; enq1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (update_valid !== (i < 2) || update_instr_info !== want[i]) begin
        n_fail++;
        $display("FAIL dual_order[%0d] got v=%b info=%h want %b %h", i, update_valid, update_instr_info, i < 2, want[i]);
      end
      cycle();
    end
    idle_inputs();
  endtask

  task automatic test_fill();
    reset_dut();
    update_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      enq0_valid = 1'b1; enq0_info = rnd_entry();
      enq1_valid = 1'b1; enq1_info = rnd_entry();
      cycle();
    end
    enq1_valid = 1'b0;
    n_checks++;
    if (count !== 4'd6 || enq_ready !== 1'b1) begin
      n_fail++; $display("FAIL fill_6 got cnt=%0d rdy=%b want 6 1", count, enq_ready);
    end
    enq0_info = rnd_entry();
    cycle();
    n_checks++;
    if (count !== 4'd7 || enq_ready !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL fill_7 got cnt=%0d rdy=%b ovf=%b want 7 0 0", count, enq_ready, overflow);
    end
    enq0_info = rnd_entry(); enq1_valid = 1'b1; enq1_info = rnd_entry();
    cycle();
    n_checks++;
    if (count !== 4'd7 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL overflow_set got cnt=%0d ovf=%b want 7 1", count, overflow);
    end
    update_ready = 1'b1;
    enq0_info = rnd_entry(); enq1_info = rnd_entry();
    cycle();
    enq0_valid = 1'b0; enq1_valid = 1'b0;
    n_checks++;
    if (count !== 4'(mq.size()) || count !== 4'd6) begin
      n_fail++; $display("FAIL full_with_deq got cnt=%0d want 6", count);
    end
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (update_valid !== (mq.size() != 0) || update_instr_info !== exp_info()) begin
        n_fail++; $display("FAIL fill_drain[%0d] got v=%b info=%h want %h", i, update_valid, update_instr_info, exp_info());
      end
      cycle();
    end
    n_checks++;
    if (overflow !== 1'b1 || count !== 4'd0) begin
      n_fail++; $display("FAIL overflow_sticky got ovf=%b cnt=%0d want 1 0", overflow, count);
    end
    reset_dut();
  endtask

  task automatic test_slot1();
    update_ready = 1'b0;
    enq1_valid = 1'b1; enq1_info = {32'h200, 1'b1};
    cycle();
    enq1_valid = 1'b0;
    n_checks++;
    if (count !== 4'd1 || update_valid !== 1'b1 || update_instr_info !== {32'h200, 1'b1}) begin
      n_fail++; $display("FAIL slot1_only got cnt=%0d v=%b info=%h want 1 1 %h", count, update_valid, update_instr_info, {32'h200, 1'b1});
    end
    update_ready = 1'b1;
    cycle();
    n_checks++;
    if (count !== 4'd0 || update_valid !== 1'b0) begin
      n_fail++; $display("FAIL slot1_drain got cnt=%0d v=%b want 0 0", count, update_valid);
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 24; i++) begin
      update_ready = (i % 3) != 2;
      enq0_valid = (mq.size() <= 4); enq0_info = rnd_entry();
      enq1_valid = (mq.size() <= 4); enq1_info = rnd_entry();
      cycle();
      n_checks++;
      if (count !== 4'(mq.size()) || update_valid !== (mq.size() != 0) || update_instr_info !== exp_info()) begin
        n_fail++;
        $display("FAIL wrap[%0d] got cnt=%0d v=%b info=%h want %0d %h", i, count, update_valid, update_instr_info, mq.size(), exp_info());
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      update_ready = 1'($urandom_range(0, 1));
      enq0_valid = ($urandom_range(0, 3) == 0); enq0_info = rnd_entry();
      enq1_valid = ($urandom_range(0, 3) == 0); enq1_info = rnd_entry();
      if (i < 250 && mq.size() > DEPTH - 2) begin
        enq0_valid = 1'b0; enq1_valid = 1'b0;
      end
      cycle();
      n_checks++;
      if (count !== 4'(mq.size()) || update_valid !== (mq.size() != 0) || update_instr_info !== exp_info() ||
          enq_ready !== (DEPTH - mq.size() >= 2) || overflow !== m_ovf) begin
        n_fail++;
        $display("FAIL random[%0d] got cnt=%0d v=%b info=%h rdy=%b ovf=%b want %0d %h ovf=%b",
                 i, count, update_valid, update_instr_info, enq_ready, overflow, mq.size(), exp_info(), m_ovf);
      end
    end
    idle_inputs();
  endtask

  initial begin
    #1 rst = 1'b1;
    test_reset();
    test_single();
    test_dual();
    test_fill();
    test_slot1();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
